ex_stage: RTL and testbench

- Execute stage of the P6 five-stage MIPS pipeline; the consuming end of the ID/EX pipeline register.
- Takes operands, immediates, one-hot instruction type and Tnew from ID/EX, and applies late forwarding from MEM and WB.
- Computes the ALU result or memory address, runs a multi-cycle HI/LO multiply/divide unit, and drives the EX/Mem pipeline register.
- EX/Mem result feeds back to ID as its EX bypass source; md_busy/md_start feed the stall unit.

---
 rtl/ex_stage_pkg.sv | 56 +++++
 rtl/ex_stage_if.sv | 45 ++++
 rtl/ex_stage_md_unit.sv | 102 ++++++++++
 rtl/ex_stage.sv | 105 ++++++++++
 tb/tb_ex_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared execute-stage constants, encodings and helpers
package ex_stage_pkg;

  localparam int ITYPE_W = 60;

  // One-hot instruction type bit positions
  localparam int I_SLL   = 0;
  localparam int I_ADDU  = 1;
  localparam int I_SUBU  = 2;
  localparam int I_AND   = 3;
  localparam int I_OR    = 4;
  localparam int I_SLT   = 5;
  localparam int I_SLTU  = 6;
  localparam int I_ORI   = 7;
  localparam int I_LW    = 8;
  localparam int I_SW    = 9;
  localparam int I_LUI   = 10;
  localparam int I_JAL   = 11;
  localparam int I_JALR  = 12;
  localparam int I_MULT  = 13;
  localparam int I_MULTU = 14;
  localparam int I_DIV   = 15;
  localparam int I_DIVU  = 16;
  localparam int I_MTHI  = 17;
  localparam int I_MTLO  = 18;
  localparam int I_MFHI  = 19;
  localparam int I_MFLO  = 20;

  localparam logic [ITYPE_W-1:0] INST_SLL = 60'd1;

  typedef enum logic [1:0] {
    FWD_IDEX = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  localparam logic [31:0] FWD_ERR = 32'h1234ABCD;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] idex,
                                          input logic [31:0] mem, input logic [31:0] wb);
    case (sel)
      FWD_IDEX: return idex;
      FWD_MEM:  return mem;
      FWD_WB:   return wb;
      default:  return FWD_ERR;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs, forwarding sources and EX/Mem outputs
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [4:0]         raddr0_in;
  logic [4:0]         raddr1_in;
  logic [4:0]         waddr_in;
  logic [4:0]         shamt_in;
  logic [31:0]        imm32_in;
  logic [ITYPE_W-1:0] instr_type_in;
  logic [31:0]        rdata0_in;
  logic [31:0]        rdata1_in;
  logic [31:0]        res_id_in;
  logic [31:0]        pc_in;
  logic [2:0]         tnew_in;
  logic [1:0]         fwd0_sel;
  logic [1:0]         fwd1_sel;
  logic [31:0]        fwd_mem;
  logic [31:0]        fwd_wb;
  logic [4:0]         waddr_ex_mem;
  logic [31:0]        res_ex_mem;
  logic [31:0]        store_data_ex_mem;
  logic [ITYPE_W-1:0] instr_type_ex_mem;
  logic [31:0]        pc_ex_mem;
  logic [2:0]         tnew_ex_mem;
  logic               md_start;
  logic               md_busy;

  modport slave (
    input  raddr0_in, raddr1_in, waddr_in, shamt_in, imm32_in, instr_type_in,
           rdata0_in, rdata1_in, res_id_in, pc_in, tnew_in, fwd0_sel, fwd1_sel,
           fwd_mem, fwd_wb,
    output waddr_ex_mem, res_ex_mem, store_data_ex_mem, instr_type_ex_mem,
           pc_ex_mem, tnew_ex_mem, md_start, md_busy
  );

  modport master (
    output raddr0_in, raddr1_in, waddr_in, shamt_in, imm32_in, instr_type_in,
           rdata0_in, rdata1_in, res_id_in, pc_in, tnew_in, fwd0_sel, fwd1_sel,
           fwd_mem, fwd_wb,
    input  waddr_ex_mem, res_ex_mem, store_data_ex_mem, instr_type_ex_mem,
           pc_ex_mem, tnew_ex_mem, md_start, md_busy
  );

endinterface

// File: rtl/ex_stage_md_unit.sv
// rtl/ex_stage_md_unit.sv - multi-cycle HI/LO multiply/divide unit
module md_unit
  import ex_stage_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             sh_vld_q, sh_vld_d;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quot_s, rem_s, quot_u, rem_u;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    quot_s = $signed(a) / $signed(b);
    rem_s  = $signed(a) % $signed(b);
    quot_u = a / b;
    rem_u  = a % b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    sh_vld_d = sh_vld_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d  = MD_BUSY;
          sh_vld_d = 1'b1;
          cnt_d    = (op == MD_DIV || op == MD_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          case (op)
            MD_MULT:  {sh_hi_d, sh_lo_d} = prod_s;
            MD_MULTU: {sh_hi_d, sh_lo_d} = prod_u;
            MD_DIV:   {sh_hi_d, sh_lo_d} = {rem_s, quot_s};
            default:  {sh_hi_d, sh_lo_d} = {rem_u, quot_u};
          endcase
          // Divide by zero still burns the busy period but leaves HI/LO alone
          if ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) sh_vld_d = 1'b0;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (sh_vld_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sh_hi_q  <= '0;
      sh_lo_q  <= '0;
      sh_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sh_hi_q  <= sh_hi_d;
      sh_lo_q  <= sh_lo_d;
      sh_vld_q <= sh_vld_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage: forwarding, ALU, mul/div, EX/Mem register
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);

  logic [ITYPE_W-1:0] it;
  logic [31:0]        op_a, op_b, alu, hi, lo;
  logic               md_start, md_busy;
  md_op_e             md_op;
  logic               unused_sig;

  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        res_q, res_d, store_q, store_d, pc_q, pc_d;
  logic [ITYPE_W-1:0] itype_q, itype_d;
  logic [2:0]         tnew_q, tnew_d;

  // Shift amount arrives already substituted into operand A
  assign unused_sig = ^{bus.raddr0_in, bus.raddr1_in, bus.shamt_in};
  assign it = bus.instr_type_in;

  always_comb begin
    op_a = fwd_mux(bus.fwd0_sel, bus.rdata0_in, bus.fwd_mem, bus.fwd_wb);
    op_b = fwd_mux(bus.fwd1_sel, bus.rdata1_in, bus.fwd_mem, bus.fwd_wb);

    alu = 32'd0;
    if (it[I_ADDU])                 alu = op_a + op_b;
    else if (it[I_SUBU])            alu = op_a - op_b;
    else if (it[I_AND])             alu = op_a & op_b;
    else if (it[I_OR])              alu = op_a | op_b;
    else if (it[I_SLT])             alu = {31'd0, $signed(op_a) < $signed(op_b)};
    else if (it[I_SLTU])            alu = {31'd0, op_a < op_b};
    else if (it[I_ORI])             alu = op_a | bus.imm32_in;
    else if (it[I_SLL])             alu = op_b << op_a[4:0];
    else if (it[I_LW] || it[I_SW])  alu = op_a + bus.imm32_in;

    md_start = it[I_MULT] | it[I_MULTU] | it[I_DIV] | it[I_DIVU];
    md_op = MD_MULT;
    if (it[I_MULTU])     md_op = MD_MULTU;
    else if (it[I_DIV])  md_op = MD_DIV;
    else if (it[I_DIVU]) md_op = MD_DIVU;

    if (bus.tnew_in == 3'd0 && bus.waddr_in != 5'd0) res_d = bus.res_id_in;
    else if (it[I_MFHI])                             res_d = hi;
    else if (it[I_MFLO])                             res_d = lo;
    else                                             res_d = alu;

    waddr_d = bus.waddr_in;
    store_d = op_b;
    itype_d = bus.instr_type_in;
    pc_d    = bus.pc_in;
    tnew_d  = (bus.tnew_in == 3'd0) ? 3'd0 : bus.tnew_in - 3'd1;
  end

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk  (clk),
    .reset(reset),
    .start(md_start),
    .op   (md_op),
    .mthi (it[I_MTHI]),
    .mtlo (it[I_MTLO]),
    .a    (op_a),
    .b    (op_b),
    .hi   (hi),
    .lo   (lo),
    .busy (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q <= '0;
      res_q   <= '0;
      store_q <= '0;
      itype_q <= INST_SLL;
      pc_q    <= 32'h0000_3000;
      tnew_q  <= '0;
    end else begin
      waddr_q <= waddr_d;
      res_q   <= res_d;
      store_q <= store_d;
      itype_q <= itype_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
    end
  end

  assign bus.waddr_ex_mem      = waddr_q;
  assign bus.res_ex_mem        = res_q;
  assign bus.store_data_ex_mem = store_q;
  assign bus.instr_type_ex_mem = itype_q;
  assign bus.pc_ex_mem         = pc_q;
  assign bus.tnew_ex_mem       = tnew_q;
  assign bus.md_start          = md_start;
  assign bus.md_busy           = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed-vector bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nop();
    bus.raddr0_in = '0; bus.raddr1_in = '0; bus.waddr_in = '0; bus.shamt_in = '0;
    bus.imm32_in = '0; bus.instr_type_in = INST_SLL; bus.rdata0_in = '0; bus.rdata1_in = '0;
    bus.res_id_in = '0; bus.pc_in = '0; bus.tnew_in = '0; bus.fwd0_sel = '0; bus.fwd1_sel = '0;
    bus.fwd_mem = '0; bus.fwd_wb = '0;
  endtask

  task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [2:0] tnew, input logic [4:0] waddr);
    nop();
    bus.instr_type_in = 60'd1 << idx;
    bus.rdata0_in = a; bus.rdata1_in = b; bus.imm32_in = imm;
    bus.tnew_in = tnew; bus.waddr_in = waddr; bus.pc_in = 32'h0000_3000 + 32'(idx * 4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    drive(I_MFHI, 0, 0, 0, 3'd1, 5'd8); tick(); hi = bus.res_ex_mem;
    drive(I_MFLO, 0, 0, 0, 3'd1, 5'd9); tick(); lo = bus.res_ex_mem;
    nop();
  endtask

  task automatic run_md(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    int c;
    drive(idx, a, b, 0, 3'd0, 5'd0);
    #1;
    expect_eq({tag, "_start"}, 64'(bus.md_start), 64'd1);
    tick();
    nop();
    c = 0;
    while (bus.md_busy === 1'b1 && c < 50) begin
      c++;
      tick();
    end
    expect_eq({tag, "_busy"}, 64'(c), 64'(exp_cycles));
  endtask

  initial begin
    logic [31:0] hi, lo;
    int c;
    nop();
    reset = 1'b1;
    drive(I_ADDU, 32'h11, 32'h22, 0, 3'd2, 5'd4);
    tick(); tick();
    expect_eq("rst_waddr", 64'(bus.waddr_ex_mem), 64'd0);
    expect_eq("rst_res", 64'(bus.res_ex_mem), 64'd0);
    expect_eq("rst_store", 64'(bus.store_data_ex_mem), 64'd0);
    expect_eq("rst_itype", 64'(bus.instr_type_ex_mem), 64'd1);
    expect_eq("rst_pc", 64'(bus.pc_ex_mem), 64'h3000);
    expect_eq("rst_tnew", 64'(bus.tnew_ex_mem), 64'd0);
    expect_eq("rst_busy", 64'(bus.md_busy), 64'd0);
    reset = 1'b0;
    read_hilo(hi, lo);
    expect_eq("rst_hi", 64'(hi), 64'd0);
    expect_eq("rst_lo", 64'(lo), 64'd0);

    // ALU vectors
    drive(I_ADDU, 32'hFFFF_FFFF, 32'd1, 0, 3'd1, 5'd3); tick();
    expect_eq("addu_wrap", 64'(bus.res_ex_mem), 64'd0);
    expect_eq("addu_tnew", 64'(bus.tnew_ex_mem), 64'd0);
    expect_eq("addu_waddr", 64'(bus.waddr_ex_mem), 64'd3);
    expect_eq("addu_store", 64'(bus.store_data_ex_mem), 64'd1);
    expect_eq("addu_itype", 64'(bus.instr_type_ex_mem), 64'd2);
    expect_eq("addu_pc", 64'(bus.pc_ex_mem), 64'h3004);

    drive(I_SUBU, 32'hAAAA, 32'hBBBB, 0, 3'd1, 5'd3);
    bus.fwd0_sel = 2'd1; bus.fwd_mem = 32'd7; bus.fwd1_sel = 2'd2; bus.fwd_wb = 32'd5; tick();
    expect_eq("subu_fwd", 64'(bus.res_ex_mem), 64'd2);

    drive(I_LW, 32'h9999, 0, 32'hFFFF_FFFC, 3'd2, 5'd6);
    bus.fwd0_sel = 2'd1; bus.fwd_mem = 32'h1000; tick();
    expect_eq("lw_addr", 64'(bus.res_ex_mem), 64'h0FFC);
    expect_eq("lw_tnew", 64'(bus.tnew_ex_mem), 64'd1);

    drive(I_SW, 32'h2000, 32'h1, 32'd8, 3'd0, 5'd0);
    bus.fwd1_sel = 2'd2; bus.fwd_wb = 32'hCAFE_F00D; tick();
    expect_eq("sw_addr", 64'(bus.res_ex_mem), 64'h2008);
    expect_eq("sw_data", 64'(bus.store_data_ex_mem), 64'hCAFE_F00D);

    drive(I_OR, 32'h5, 32'd0, 0, 3'd1, 5'd2); bus.fwd0_sel = 2'd3; tick();
    expect_eq("fwd_err", 64'(bus.res_ex_mem), 64'h1234_ABCD);

    drive(I_SLT, 32'hFFFF_FFFF, 32'd1, 0, 3'd1, 5'd2); tick();
    expect_eq("slt", 64'(bus.res_ex_mem), 64'd1);
    drive(I_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 3'd1, 5'd2); tick();
    expect_eq("sltu", 64'(bus.res_ex_mem), 64'd0);
    drive(I_ORI, 32'hF0, 32'd0, 32'h0F, 3'd1, 5'd2); tick();
    expect_eq("ori", 64'(bus.res_ex_mem), 64'hFF);
    drive(I_SLL, 32'd4, 32'd3, 0, 3'd1, 5'd2); tick();
    expect_eq("sll", 64'(bus.res_ex_mem), 64'h30);
    drive(I_AND, 32'hF0F0, 32'h0FF0, 0, 3'd4, 5'd2); tick();
    expect_eq("and", 64'(bus.res_ex_mem), 64'h00F0);
    expect_eq("tnew_dec", 64'(bus.tnew_ex_mem), 64'd3);

    // Result source selection
    drive(I_JAL, 0, 0, 0, 3'd0, 5'd31); bus.res_id_in = 32'h3008; tick();
    expect_eq("jal_res", 64'(bus.res_ex_mem), 64'h3008);
    drive(I_ADDU, 32'd2, 32'd3, 0, 3'd0, 5'd0); bus.res_id_in = 32'hDEAD; tick();
    expect_eq("tnew0_w0", 64'(bus.res_ex_mem), 64'd5);

    drive(I_MTHI, 32'h55, 0, 0, 3'd0, 5'd0); tick();
    drive(I_MFHI, 0, 0, 0, 3'd1, 5'd8); tick();
    expect_eq("mthi_mfhi", 64'(bus.res_ex_mem), 64'h55);

    // Multiply / divide
    run_md("mult", I_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo(hi, lo);
    expect_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    expect_eq("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    run_md("multu", I_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo(hi, lo);
    expect_eq("multu_hi", 64'(hi), 64'd2);
    expect_eq("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    run_md("div", I_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo(hi, lo);
    expect_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);
    expect_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);

    run_md("divu0", I_DIVU, 32'd100, 32'd0, 10);
    read_hilo(hi, lo);
    expect_eq("divu0_hi", 64'(hi), 64'hFFFF_FFFF);
    expect_eq("divu0_lo", 64'(lo), 64'hFFFF_FFFD);

    // A second start while busy must be ignored
    drive(I_MULT, 32'd2, 32'd3, 0, 3'd0, 5'd0); tick(); nop();
    c = 0;
    if (bus.md_busy === 1'b1) c++;
    drive(I_DIVU, 32'd100, 32'd7, 0, 3'd0, 5'd0); tick(); nop();
    while (bus.md_busy === 1'b1 && c < 50) begin
      c++;
      tick();
    end
    expect_eq("overlap_busy", 64'(c), 64'd5);
    read_hilo(hi, lo);
    expect_eq("overlap_hi", 64'(hi), 64'd0);
    expect_eq("overlap_lo", 64'(lo), 64'd6);

    // Reset in the middle of a divide
    drive(I_MTHI, 32'h77, 0, 0, 3'd0, 5'd0); tick();
    drive(I_MTLO, 32'h66, 0, 0, 3'd0, 5'd0); tick();
    read_hilo(hi, lo);
    expect_eq("pre_rst_hi", 64'(hi), 64'h77);
    expect_eq("pre_rst_lo", 64'(lo), 64'h66);
    drive(I_DIV, 32'd100, 32'd7, 0, 3'd0, 5'd0); tick(); nop();
    tick(); tick();
    expect_eq("mid_busy", 64'(bus.md_busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    expect_eq("abort_busy", 64'(bus.md_busy), 64'd0);
    expect_eq("abort_pc", 64'(bus.pc_ex_mem), 64'h3000);
    repeat (10) tick();
    expect_eq("abort_stays_idle", 64'(bus.md_busy), 64'd0);
    read_hilo(hi, lo);
    expect_eq("abort_hi", 64'(hi), 64'd0);
    expect_eq("abort_lo", 64'(lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
